des_cbc_feeder: RTL

- Sequential front/back end for the combinational DES core (64-bit in, 64-bit key, 64-bit out).
- Packs an 8-bit byte stream into 64-bit blocks and optionally applies CBC chaining (XOR with IV or previous ciphertext).
- Drives the registered block and key into the core, captures the core result after a programmable settle time, and presents ciphertext blocks on a valid/ready output.

---
 rtl/des_cbc_feeder.sv | 120 ++++++++++++
 1 files changed

// File: rtl/des_cbc_feeder.sv
// Byte-stream packer and CBC chainer wrapped around a combinational DES core.
// Builds 64-bit blocks, drives the core, captures its result, hands it out.
module des_cbc_feeder #(
    parameter int CORE_WAIT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_load,
    input  logic [63:0] key,
    input  logic        iv_load,
    input  logic [63:0] iv,
    input  logic        mode_cbc,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic [63:0] core_in,
    output logic [63:0] core_key,
    input  logic [63:0] core_out,
    output logic        blk_valid,
    output logic [63:0] blk_data,
    input  logic        blk_ready,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_FILL,
        S_LAUNCH,
        S_WAIT,
        S_OUT
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [3:0]  wait_q, wait_d;
    logic [63:0] buf_q, buf_d;
    logic [63:0] chain_q, chain_d;
    logic [63:0] cin_q, cin_d;
    logic [63:0] key_q, key_d;
    logic [63:0] blk_q, blk_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FILL;
            cnt_q   <= '0;
            wait_q  <= '0;
            buf_q   <= '0;
            chain_q <= '0;
            cin_q   <= '0;
            key_q   <= '0;
            blk_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wait_q  <= wait_d;
            buf_q   <= buf_d;
            chain_q <= chain_d;
            cin_q   <= cin_d;
            key_q   <= key_d;
            blk_q   <= blk_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wait_d     = wait_q;
        buf_d      = buf_q;
        chain_d    = chain_q;
        cin_d      = cin_q;
        key_d      = key_q;
        blk_d      = blk_q;
        byte_ready = 1'b0;
        blk_valid  = 1'b0;
        unique case (state_q)
            S_FILL: begin
                byte_ready = 1'b1;
                // Loads only land on a block boundary so a block never mixes keys/IVs
                if (cnt_q == 3'd0) begin
                    if (key_load) key_d = key;
                    if (iv_load) chain_d = iv;
                end
                if (byte_valid) begin
                    buf_d = {buf_q[55:0], byte_data};
                    if (cnt_q == 3'd7) begin
                        cnt_d   = 3'd0;
                        state_d = S_LAUNCH;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            S_LAUNCH: begin
                cin_d   = mode_cbc ? (buf_q ^ chain_q) : buf_q;
                wait_d  = 4'(CORE_WAIT);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                wait_d = wait_q - 4'd1;
                if (wait_q == 4'd1) begin
                    blk_d   = core_out;
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                blk_valid = 1'b1;
                if (blk_ready) begin
                    chain_d = blk_q;
                    state_d = S_FILL;
                end
            end
            default: state_d = S_FILL;
        endcase
    end

    assign core_in  = cin_q;
    assign core_key = key_q;
    assign blk_data = blk_q;
    assign busy     = (state_q != S_FILL) || (cnt_q != 3'd0);

endmodule
